rtst_shifter: RTL and testbench

- Registered 6-bit shift/rotate unit used as the shift stage of the ALU datapath.
- Takes operand a and shift amount b, applies the operation selected by op, and registers the result s with zero and carry flags.
- Result appears one clock after the inputs are sampled.
- Default operation (op=00, logical right shift) gives s=1 for a=8, b=3.

---
 rtl/rtst_shifter_pkg.sv | 12 +
 rtl/rtst_barrel_core.sv | 47 ++++
 rtl/rtst_shifter.sv | 66 ++++++
 tb/tb_rtst_shifter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtst_shifter_pkg.sv
// Shared constants for the rtst_shifter shift/rotate stage.
package rtst_shifter_pkg;

    localparam int unsigned W   = 6;
    localparam int unsigned SHW = $clog2(W);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SLL = 2'b11;

endpackage

// File: rtl/rtst_barrel_core.sv
// Combinational log-stage barrel shifter; amt must already be reduced below W.
module rtst_barrel_core
    import rtst_shifter_pkg::*;
(
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [SHW-1:0] amt,
    output logic [W-1:0]   res_c,
    output logic           carry_c
);

    logic [W-1:0]   data;
    logic [W-1:0]   probe;
    logic [2*W-1:0] ext;
    logic           guard;
    logic           fill;

    // guard tracks the last bit pushed out; the final active stage leaves the overall last one
    always_comb begin
        data  = a;
        guard = 1'b0;
        ext   = '0;
        probe = '0;
        fill  = (op == OP_SRA) & a[W-1];
        for (int unsigned k = 0; k < SHW; k++) begin
            if (amt[k]) begin
                if (op == OP_SLL) begin
                    probe = data >> (W - (32'd1 << k));
                    ext   = {{W{1'b0}}, data} << (32'd1 << k);
                end else begin
                    probe = data >> ((32'd1 << k) - 32'd1);
                    if (op == OP_ROR) begin
                        ext = {data, data} >> (32'd1 << k);
                    end else begin
                        ext = {{W{fill}}, data} >> (32'd1 << k);
                    end
                end
                guard = probe[0];
                data  = ext[W-1:0];
            end
        end
    end

    assign res_c   = data;
    assign carry_c = (op == OP_ROR) ? ((amt != '0) & data[W-1]) : guard;

endmodule

// File: rtl/rtst_shifter.sv
// Registered shift/rotate stage: amount clamping, zero flag and output registers.
module rtst_shifter
    import rtst_shifter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         zero,
    output logic         carry,
    output logic         out_valid
);

    logic           over;
    logic [SHW-1:0] amt;
    logic [W-1:0]   core_res;
    logic           core_carry;
    logic [W-1:0]   s_nxt;
    logic           carry_nxt;

    assign over = 32'(b) >= W;
    assign amt  = SHW'(32'(b) % W);

    rtst_barrel_core u_core (
        .op      (op),
        .a       (a),
        .amt     (amt),
        .res_c   (core_res),
        .carry_c (core_carry)
    );

    // Out-of-range amounts saturate for shifts; rotates always wrap mod W
    always_comb begin
        s_nxt     = core_res;
        carry_nxt = core_carry;
        if (over && (op != OP_ROR)) begin
            if (op == OP_SRA) begin
                s_nxt     = {W{a[W-1]}};
                carry_nxt = a[W-1];
            end else begin
                s_nxt     = '0;
                carry_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s     <= s_nxt;
                zero  <= (s_nxt == '0);
                carry <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rtst_shifter.sv
// Directed-vector bench for rtst_shifter.
module tb_rtst_shifter;
    import rtst_shifter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   op = OP_SRL;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] s;
    logic         zero;
    logic         carry;
    logic         out_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rtst_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .s         (s),
        .zero      (zero),
        .carry     (carry),
        .out_valid (out_valid)
    );

    task automatic drive(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op       = o;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed word is {out_valid, zero, carry, s}
    task automatic test_reset();
        logic [W+2:0] exp;
        rst_n = 1'b0;
        drive(OP_SRL, 6'd8, 6'd3);
        step();
        step();
        exp = {1'b0, 1'b0, 1'b0, 6'd0};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL reset_hold got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_SRL, 6'd8, 6'd3);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'd1};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL srl_first got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
    endtask

    task automatic test_sra();
        logic [W+2:0] exp;
        @(negedge clk);
        drive(OP_SRA, 6'b100100, 6'd2);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'b111001};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL sra_b2 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SRA, 6'b100100, 6'd9);
        step();
        exp = {1'b1, 1'b0, 1'b1, 6'b111111};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL sra_b9 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SRA, 6'b100100, 6'd0);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'b100100};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL sra_b0 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
    endtask

    task automatic test_ror();
        logic [W+2:0] exp;
        drive(OP_ROR, 6'b000011, 6'd1);
        step();
        exp = {1'b1, 1'b0, 1'b1, 6'b100001};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL ror_b1 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_ROR, 6'b000011, 6'd7);
        step();
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL ror_b7 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_ROR, 6'b101100, 6'd12);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'b101100};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL ror_b12 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_ROR, 6'b101100, 6'd3);
        step();
        exp = {1'b1, 1'b0, 1'b1, 6'b100101};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL ror_b3 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
    endtask

    task automatic test_sll_zero();
        logic [W+2:0] exp;
        drive(OP_SLL, 6'd8, 6'd3);
        step();
        exp = {1'b1, 1'b1, 1'b1, 6'd0};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL sll_8_3 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SLL, 6'd1, 6'd6);
        step();
        exp = {1'b1, 1'b1, 1'b0, 6'd0};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL sll_1_6 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SLL, 6'b010011, 6'd5);
        step();
        exp = {1'b1, 1'b0, 1'b1, 6'b100000};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL sll_b5 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SRL, 6'd63, 6'd6);
        step();
        exp = {1'b1, 1'b1, 1'b0, 6'd0};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL srl_over got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SRL, 6'b110110, 6'd5);
        step();
        exp = {1'b1, 1'b0, 1'b1, 6'b000001};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL srl_b5 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] exp;
        drive(OP_SRL, 6'd8, 6'd3);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'd1};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL b2b_0 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_SLL, 6'd1, 6'd2);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'd4};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL b2b_1 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        drive(OP_ROR, 6'd1, 6'd1);
        step();
        exp = {1'b1, 1'b0, 1'b1, 6'd32};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL b2b_2 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        in_valid = 1'b0;
        a        = 6'd0;
        b        = 6'd0;
        step();
        exp = {1'b0, 1'b0, 1'b1, 6'd32};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL hold_0 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        step();
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL hold_1 got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [W+2:0] exp;
        drive(OP_SRA, 6'b110000, 6'd4);
        step();
        exp = {1'b1, 1'b0, 1'b0, 6'b111111};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL pre_areset got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp = {1'b0, 1'b0, 1'b0, 6'd0};
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL areset_now got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        vectors++;
        if ({out_valid, zero, carry, s} !== exp) begin
            miscompares++;
            $display("FAIL post_areset got=%b want=%b", {out_valid, zero, carry, s}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_sra();
        test_ror();
        test_sll_zero();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
